pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the payload.
REQ-002 SHALL have parameter RESET_DATA, default 0, value loaded into both data slots at reset.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  upstream payload.
REQ-008 SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  entry present at output.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  output payload.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the entry this cycle.
REQ-012 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-013 SHALL treat a transfer as occurring on a rising edge where valid and ready are both high on that side.
REQ-014 SHALL hold two slots: main (drives out_data) and skid, with states EMPTY (0 entries), FULL (main only), SKID (main and skid).
REQ-015 SHALL drive out_valid = (state != EMPTY), in_ready = (state != SKID) and occupancy = 0/1/2 for EMPTY/FULL/SKID, all decoded from registered state only, with no combinational path from out_ready or in_valid to any output.
REQ-016 SHALL perform the following transitions in EMPTY:
- in_valid: main <= in_data, go to FULL.
- otherwise: stay in EMPTY.
REQ-017 SHALL perform the following transitions in FULL:
- in_valid & out_ready: main <= in_data, stay in FULL.
- in_valid & !out_ready: skid <= in_data, go to SKID.
- !in_valid & out_ready: go to EMPTY.
- otherwise: hold.
REQ-018 SHALL perform the following transitions in SKID:
- out_ready: main <= skid, go to FULL; no input is accepted because in_ready is 0.
- otherwise: hold both slots.
REQ-019 SHALL have a latency of 1 cycle: an entry accepted at edge N appears on out_data/out_valid after edge N when the block was EMPTY.
REQ-020 SHALL preserve order and never drop or duplicate entries outside flush; throughput SHALL be 1 entry/cycle while out_ready stays high.
REQ-021 SHALL give flush priority over all transitions: next state is EMPTY and any input transfer on that edge is discarded.
REQ-022 SHALL leave slot data unchanged on flush; out_data is don't-care while out_valid = 0.
REQ-023 SHALL keep out_data stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL ignore in_data entirely when in_valid = 0.

Reset
REQ-025 SHALL, on rst_n low, immediately force state = EMPTY, main = skid = RESET_DATA, out_valid = 0, in_ready = 1 and occupancy = 0, independent of clk.
REQ-026 SHALL discard any held entries when reset is asserted mid-operation, and SHALL accept no transfer on the first edge after rst_n deasserts unless in_valid is high.

Structure
REQ-027 SHALL define its state encodings (EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2) in the shared defines file; state value 2'd3 SHALL map to EMPTY on the next edge.
REQ-028 SHALL use one sub-module, pipe_slot: a DATA_WIDTH load-enable data register with asynchronous active-low reset to RESET_DATA, instantiated twice (main, skid).

Verification
REQ-029 SHALL cover streaming: in_valid = 1 and out_ready = 1 for 8 cycles with data 1..8 -> out_data 1..8 one cycle later, occupancy stays 1, in_ready stays 1.
REQ-030 SHALL cover backpressure: FULL holding 0xA, then out_ready = 0 while 0xB is offered -> SKID, in_ready = 0, out_data = 0xA; out_ready = 1 -> 0xA, then 0xB, in order, with no loss.
REQ-031 SHALL cover flush in SKID with in_valid = 1 and data 0xC -> next cycle out_valid = 0, occupancy = 0, and 0xC never appears.
REQ-032 SHALL cover reset mid-SKID asserted between clock edges -> out_valid = 0 and in_ready = 1 immediately, and out_data = RESET_DATA.
REQ-033 SHALL cover random valid/ready toggling for 10k cycles against a reference queue -> zero mismatches, no output depends combinationally on inputs, and occupancy never exceeds 2.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared state encodings and decode helper for the pipe_skid_reg skid buffer.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // The unused code 2'd3 reports zero entries, matching its recovery to EMPTY.
  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ST_FULL: return 2'd1;
      ST_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Load-enable payload register with async active-low reset to RESET_DATA.
// Latency 1 cycle from ld_i to q_o; no flow control of its own.
module pipe_slot #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_DATA;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: fully registered valid/ready on both sides, 1-cycle latency.
// Backpressure: in_ready drops only once the skid slot holds an entry.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  state_e                state_q, state_d;
  logic                  main_ld, skid_ld, main_from_skid;
  logic [DATA_WIDTH-1:0] main_d, main_q, skid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          main_ld = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_valid && out_ready) begin
          main_ld = 1'b1;
        end else if (in_valid) begin
          skid_ld = 1'b1;
          state_d = ST_SKID;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_ready) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush empties the pipe but leaves slot contents untouched.
    if (flush) begin
      state_d = ST_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  pipe_slot #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_i  (skid_ld),
    .d_i   (in_data),
    .q_o   (skid_q)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_SKID);
  assign occupancy = occ_of(state_q);
  assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random traffic against a FIFO-queue model.
module tb_pipe_skid_reg;

  localparam int          DW    = 32;
  localparam logic [31:0] RDATA = 32'h5A5A_0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: ordered list of held entries, capacity two.
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .DATA_WIDTH (DW),
    .RESET_DATA (RDATA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, "/in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    chk({tag, "/occupancy"}, 32'(occupancy), 32'(mq.size()));
    chk({tag, "/occ_max"},   32'(occupancy <= 2'd2), 32'd1);
    if (mq.size() != 0) chk({tag, "/out_data"}, out_data, mq[0]);
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] id, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  // Advance one edge, apply the transfer rules to the model, then check at the falling edge.
  task automatic cycle(input string tag);
    bit take_out, take_in;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      take_out = (mq.size() != 0) && out_ready;
      take_in  = (mq.size() < 2) && in_valid;
      if (take_out) void'(mq.pop_front());
      if (take_in) mq.push_back(in_data);
    end
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/in_ready",  32'(in_ready),  32'd1);
    chk("rst/occupancy", 32'(occupancy), 32'd0);
    chk("rst/out_data",  out_data,       RDATA);
    rst_n = 1'b1;
    cycle("idle");

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 32'(i), 1'b1);
      cycle("stream");
      chk("stream/data", out_data, 32'(i));
      chk("stream/occ",  32'(occupancy), 32'd1);
      chk("stream/rdy",  32'(in_ready), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    cycle("drain");

    // Backpressure into the skid slot
    drive(1'b0, 1'b1, 32'hA, 1'b0);
    cycle("bp_fill");
    drive(1'b0, 1'b1, 32'hB, 1'b0);
    cycle("bp_skid");
    chk("bp/in_ready", 32'(in_ready),  32'd0);
    chk("bp/occ",      32'(occupancy), 32'd2);
    chk("bp/data_a",   out_data,       32'hA);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    cycle("bp_rel1");
    chk("bp/data_b", out_data, 32'hB);
    cycle("bp_rel2");
    chk("bp/empty", 32'(out_valid), 32'd0);

    // Flush while in SKID with a competing input
    drive(1'b0, 1'b1, 32'h1, 1'b0);
    cycle("fl_fill1");
    drive(1'b0, 1'b1, 32'h2, 1'b0);
    cycle("fl_fill2");
    drive(1'b1, 1'b1, 32'hC, 1'b0);
    cycle("flush");
    chk("flush/out_valid", 32'(out_valid), 32'd0);
    chk("flush/occ",       32'(occupancy), 32'd0);
    drive(1'b0, 1'b0, 32'hC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle("post_flush");
      chk("flush/no_c", 32'(out_valid && out_data == 32'hC), 32'd0);
    end

    // Asynchronous reset between edges while in SKID
    drive(1'b0, 1'b1, 32'h3, 1'b0);
    cycle("rs_fill1");
    drive(1'b0, 1'b1, 32'h4, 1'b0);
    cycle("rs_fill2");
    chk("rs/occ_before", 32'(occupancy), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rs/out_valid", 32'(out_valid), 32'd0);
    chk("rs/in_ready",  32'(in_ready),  32'd1);
    chk("rs/occupancy", 32'(occupancy), 32'd0);
    chk("rs/out_data",  out_data,       RDATA);
    mq.delete();
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h55, 1'b1);
    rst_n = 1'b1;
    cycle("rs_release");
    chk("rs/no_accept", 32'(out_valid), 32'd0);

    // Random traffic with phases of varying backpressure
    for (int c = 0; c < 10000; c++) begin
      int ordy_pct;
      ordy_pct = (c / 500) % 4 == 0 ? 90 : ((c / 500) % 4 == 1 ? 20 : 50);
      drive(($urandom_range(63) == 0), ($urandom_range(99) < 60), $urandom,
            ($urandom_range(99) < ordy_pct));
      #1;
      check_model("comb");
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
